// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NUM_REQ requesters; optional grant counters via ALU_ARB_STATS_EN.
// Latency: grant in cycle N, response valid in cycle N+2; at least 3 cycles per op.
// Backpressure: response held until rsp_ready; no new grant issued while an op is in flight.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]    req_op,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]   grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] win;
  logic            found;
  logic [31:0]     opa, opb;
  logic [3:0]      opc;

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == IDLE) && found && (win == ID_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_a  = opa;
  assign alu_b  = opb;
  assign alu_op = opc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= ID_W'(NUM_REQ - 1);
      id         <= '0;
      opa        <= '0;
      opb        <= '0;
      opc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            opa  <= req_a[32*int'(win) +: 32];
            opb  <= req_b[32*int'(win) +: 32];
            opc  <= req_op[4*int'(win) +: 4];
            last <= win;
            id   <= win;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_id     <= id;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (state == IDLE && found) begin
      grant_cnt[16*int'(win) +: 16] <= grant_cnt[16*int'(win) +: 16] + 16'd1;
    end
  end
`endif

endmodule
